// File: rtl/vending_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : vending_fsm_if
//  Description : Coin-in / dispense-out signal bundle for vending_fsm.
//                The master side is the coin-acceptor front end plus the
//                actuators. The slave side is the vending controller.
//                Optional macro VEND_SALES_CNT_EN adds the sales_count
//                output.
//  Revision    : 1.0  initial release
// ============================================================================
interface vending_fsm_if;
    logic [1:0] coin;
    logic       product;
    logic       change;
`ifdef VEND_SALES_CNT_EN
    logic [7:0] sales_count;
`endif

    // Front end: drives coins and watches the actuator pulses.
    modport master (
        output coin,
`ifdef VEND_SALES_CNT_EN
        input  sales_count,
`endif
        input  product,
        input  change
    );

    // Controller: consumes coins and produces the actuator pulses.
    modport slave (
        input  coin,
`ifdef VEND_SALES_CNT_EN
        output sales_count,
`endif
        output product,
        output change
    );
endinterface
`default_nettype wire

// File: rtl/vending_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : vending_fsm
//  Description : Single-product vending controller, price 3 rupees.
//                Accepts 1- and 2-rupee coins, one encoded coin per clock.
//                Emits a one-cycle product pulse when credit reaches the
//                price, plus a one-cycle 1-rupee change pulse on overpay.
//                Optional macro VEND_SALES_CNT_EN adds an 8-bit wrapping
//                sales counter on the interface.
//  Revision    : 1.0  initial release
// ============================================================================
module vending_fsm (
    input  wire logic      clk,
    input  wire logic      rst,
    vending_fsm_if.slave   bus
);

    // The state value is the accumulated credit in rupees.
    typedef enum logic [1:0] {
        S0       = 2'b00,
        S1       = 2'b01,
        S2       = 2'b10,
        S_UNUSED = 2'b11
    } state_t;

    localparam logic [1:0] c_COIN_ONE = 2'b01;
    localparam logic [1:0] c_COIN_TWO = 2'b10;

    state_t pr_state;
    state_t w_nx_state;
    logic   w_product;
    logic   w_change;
    logic   r_product;
    logic   r_change;

    // Next credit and the pulses that are registered on the same edge.
    // The invalid coin code 2'b11 falls into the defaults and keeps credit.
    always_comb begin
        w_nx_state = pr_state;
        w_product  = 1'b0;
        w_change   = 1'b0;
        case (pr_state)
            S0: begin
                if (bus.coin == c_COIN_ONE)      w_nx_state = S1;
                else if (bus.coin == c_COIN_TWO) w_nx_state = S2;
            end
            S1: begin
                if (bus.coin == c_COIN_ONE) begin
                    w_nx_state = S2;
                end else if (bus.coin == c_COIN_TWO) begin
                    w_nx_state = S0;
                    w_product  = 1'b1;
                end
            end
            S2: begin
                if (bus.coin == c_COIN_ONE) begin
                    w_nx_state = S0;
                    w_product  = 1'b1;
                end else if (bus.coin == c_COIN_TWO) begin
                    w_nx_state = S0;
                    w_product  = 1'b1;
                    w_change   = 1'b1;
                end
            end
            // The unused encoding drops straight back to zero credit.
            default: w_nx_state = S0;
        endcase
    end

    // State and output registers; reset wins over a completing coin.
    always_ff @(posedge clk) begin
        if (rst) begin
            pr_state  <= S0;
            r_product <= 1'b0;
            r_change  <= 1'b0;
        end else begin
            pr_state  <= w_nx_state;
            r_product <= w_product;
            r_change  <= w_change;
        end
    end

    assign bus.product = r_product;
    assign bus.change  = r_change;

`ifdef VEND_SALES_CNT_EN
    logic [7:0] r_sales_count;

    // Count every vend; the 8-bit counter wraps naturally from 255 to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sales_count <= 8'd0;
        end else if (w_product) begin
            r_sales_count <= r_sales_count + 8'd1;
        end
    end

    assign bus.sales_count = r_sales_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vending_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vending_fsm
//  Description : Directed self-checking bench for vending_fsm. Each step
//                drives rst/coin, waits one rising edge and checks credit,
//                product and change against hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vending_fsm;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    vending_fsm_if bus ();

    vending_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison with its immediate assertion.
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Apply rst/coin for one edge, then check credit and both pulses.
    task automatic step(input string tag, input logic r, input logic [1:0] c,
                        input logic [1:0] es, input logic ep, input logic ec);
        rst      = r;
        bus.coin = c;
        @(posedge clk);
        #1;
        check({tag, ".state"},   {6'd0, dut.pr_state}, {6'd0, es});
        check({tag, ".product"}, {7'd0, bus.product},  {7'd0, ep});
        check({tag, ".change"},  {7'd0, bus.change},   {7'd0, ec});
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        rst      = 1'b1;
        bus.coin = 2'b00;

        // Reset held with a coin present: no credit builds up.
        step("rst0", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
        step("rst1", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0);

        // 1+1+1 exact pay.
        step("e111_a", 1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
        step("e111_b", 1'b0, 2'b01, 2'b10, 1'b0, 1'b0);
        step("e111_c", 1'b0, 2'b01, 2'b00, 1'b1, 1'b0);
        step("e111_d", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

        // 1+1+idle+2 overpay.
        step("o112_a", 1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
        step("o112_b", 1'b0, 2'b01, 2'b10, 1'b0, 1'b0);
        step("o112_i", 1'b0, 2'b00, 2'b10, 1'b0, 1'b0);
        step("o112_c", 1'b0, 2'b10, 2'b00, 1'b1, 1'b1);

        // 1+2 exact pay straight after a vend.
        step("e12_i",  1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        step("e12_a",  1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
        step("e12_inv",1'b0, 2'b11, 2'b01, 1'b0, 1'b0);
        step("e12_b",  1'b0, 2'b10, 2'b00, 1'b1, 1'b0);
        step("e12_d",  1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

        // Back-to-back vends: 2+1 then immediately 2+2.
        step("bb_a",   1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
        step("bb_b",   1'b0, 2'b01, 2'b00, 1'b1, 1'b0);
        step("bb_c",   1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
        step("bb_d",   1'b0, 2'b10, 2'b00, 1'b1, 1'b1);

        // Invalid coin at S2, then reset against a completing coin.
        step("inv_a",  1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
        step("inv_b",  1'b0, 2'b11, 2'b10, 1'b0, 1'b0);
        step("inv_r",  1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
        step("inv_n",  1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

`ifdef VEND_SALES_CNT_EN
        // Sales counter: clear, one vend, then wrap after 257 vends total.
        step("cnt_r",  1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
        check("cnt_clr", bus.sales_count, 8'd0);
        step("cnt_a",  1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
        step("cnt_b",  1'b0, 2'b01, 2'b00, 1'b1, 1'b0);
        check("cnt_one", bus.sales_count, 8'd1);
        for (int i = 1; i < 257; i++) begin
            rst      = 1'b0;
            bus.coin = 2'b10;
            @(posedge clk);
            #1;
            bus.coin = 2'b01;
            @(posedge clk);
            #1;
        end
        check("cnt_wrap", bus.sales_count, 8'd1);
        step("cnt_r2", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
        check("cnt_rst", bus.sales_count, 8'd0);
`endif

        rst      = 1'b0;
        bus.coin = 2'b00;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
